// File: rtl/fetch_queue_if.sv
// Bundle of the CPU-side instruction stream and the memory-side fetch port of
// fetch_queue. The master modport is the queue itself; slave is its environment.
interface fetch_queue_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_addr;
   logic              mem_hold;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  redirect, redirect_pc, instr_ready, mem_hold, mem_ack, mem_rdata,
      output instr_valid, instr_data, instr_addr, mem_req, mem_addr
   );

   modport slave (
      output redirect, redirect_pc, instr_ready, mem_hold, mem_ack, mem_rdata,
      input  instr_valid, instr_data, instr_addr, mem_req, mem_addr
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches ahead of the CPU,
// buffers up to DEPTH words and flushes on a control-flow redirect.
module fetch_queue #(
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 32,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     resetn,
   fetch_queue_if.master            bus,
   output logic [1:0]               dbg_state,
   output logic [$clog2(DEPTH):0]   dbg_count
);
   localparam int                PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] INC   = ADDR_W'(DATA_W / 8);
   localparam logic [PTR_W:0]    FULL  = (PTR_W + 1)'(DEPTH);

   // Handshakes: an instruction moves when instr_valid && instr_ready in the
   // same cycle; a fetch completes on the cycle mem_ack pulses while mem_req=1,
   // and mem_req/mem_addr stay stable until then.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [ADDR_W-1:0]  entry_addr_q [DEPTH];
   logic [DATA_W-1:0]  entry_data_q [DEPTH];

   logic               push;
   logic               pop;
   logic [PTR_W:0]     count_next;

   // Redirect suppresses both push and pop; the flush wins that edge.
   always_comb begin
      push       = (state_q == ST_REQ) && bus.mem_ack && !bus.redirect;
      pop        = (count_q != '0) && bus.instr_ready && !bus.redirect;
      count_next = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      fetch_addr_d = fetch_addr_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_next;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            // count_next < FULL reserves a slot for the request being issued.
            if (!bus.redirect && !bus.mem_hold && (count_next < FULL)) begin
               state_d    = ST_REQ;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_addr_q;
            end
         end
         ST_REQ: begin
            if (bus.mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (!bus.redirect) fetch_addr_d = fetch_addr_q + INC;
            end else if (bus.redirect) begin
               state_d = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (bus.mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (bus.redirect) begin
         fetch_addr_d = bus.redirect_pc;
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= RESET_PC;
         fetch_addr_q <= RESET_PC;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         fetch_addr_q <= fetch_addr_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entry_addr_q[wr_ptr_q] <= mem_addr_q;
         entry_data_q[wr_ptr_q] <= bus.mem_rdata;
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.instr_valid = (count_q != '0);
   assign bus.instr_addr  = entry_addr_q[rd_ptr_q];
   assign bus.instr_data  = entry_data_q[rd_ptr_q];
   assign dbg_state       = state_q;
   assign dbg_count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reset-PC-0 instance for streaming, fill,
// redirect and hold, and a wrap-around instance for address wrap and async reset.
module tb_fetch_queue;
   localparam logic [31:0] MAGIC = 32'hA5A5_A5A5;

   logic       clk;
   logic       rst0_n;
   logic       rst1_n;
   logic [1:0] dbg_state0, dbg_state1;
   logic [2:0] dbg_count0, dbg_count1;

   int checks   = 0;
   int failures = 0;
   int ack_cnt  = 0;
   int age      = 0;
   bit auto_mem = 0;

   logic [31:0] exp_q[$];

   fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

   fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut0 (
      .clk(clk), .resetn(rst0_n), .bus(bus0),
      .dbg_state(dbg_state0), .dbg_count(dbg_count0)
   );

   fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
      .clk(clk), .resetn(rst1_n), .bus(bus1),
      .dbg_state(dbg_state1), .dbg_count(dbg_count1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // memory responder for dut0: acks two cycles after the request is seen
   always @(negedge clk) begin
      if (auto_mem) begin
         bus0.mem_ack = 1'b0;
         if (bus0.mem_req && rst0_n) begin
            if (age == 2) begin
               bus0.mem_ack   = 1'b1;
               bus0.mem_rdata = bus0.mem_addr ^ MAGIC;
               ack_cnt++;
               age = 0;
            end else begin
               age++;
            end
         end else begin
            age = 0;
         end
      end
   end

   // scoreboard: every instruction taken by the CPU must be the next expected one
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst0_n && bus0.instr_valid && bus0.instr_ready && !bus0.redirect) begin
         check("exp_avail", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("head_addr", 64'(bus0.instr_addr), 64'(e));
            check("head_data", 64'(bus0.instr_data), 64'(e ^ MAGIC));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req_at(input int which, input logic [31:0] addr, input int max_cyc,
                              input string tag);
      bit hit = 1'b0;
      for (int n = 0; n < max_cyc && !hit; n++) begin
         tick();
         if (which == 0) hit = bus0.mem_req && (bus0.mem_addr == addr);
         else            hit = bus1.mem_req && (bus1.mem_addr == addr);
      end
      check(tag, 64'(hit), 64'(1));
   endtask

   task automatic ack_pulse(input int which, input logic [31:0] data);
      if (which == 0) begin
         bus0.mem_ack = 1'b1; bus0.mem_rdata = data;
      end else begin
         bus1.mem_ack = 1'b1; bus1.mem_rdata = data;
      end
      tick();
      if (which == 0) bus0.mem_ack = 1'b0;
      else            bus1.mem_ack = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc, input string tag);
      for (int n = 0; n < max_cyc && exp_q.size() != 0; n++) tick();
      check(tag, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic reset0();
      rst0_n = 1'b0;
      tick();
      exp_q.delete();
      ack_cnt = 0;
      rst0_n = 1'b1;
   endtask

   initial begin
      rst0_n = 1'b0; rst1_n = 1'b0;
      bus0.redirect = 1'b0; bus0.redirect_pc = '0; bus0.instr_ready = 1'b0;
      bus0.mem_hold = 1'b0; bus0.mem_ack = 1'b0; bus0.mem_rdata = '0;
      bus1.redirect = 1'b0; bus1.redirect_pc = '0; bus1.instr_ready = 1'b0;
      bus1.mem_hold = 1'b0; bus1.mem_ack = 1'b0; bus1.mem_rdata = '0;
      tick(); tick();

      // reset state and startup
      check("rst_mem_req", 64'(bus0.mem_req), 64'(0));
      check("rst_valid", 64'(bus0.instr_valid), 64'(0));
      check("rst_mem_addr", 64'(bus0.mem_addr), 64'(0));
      check("rst_count", 64'(dbg_count0), 64'(0));
      check("rst_state", 64'(dbg_state0), 64'(0));
      auto_mem = 1'b1;
      bus0.instr_ready = 1'b1;
      rst0_n = 1'b1;
      tick();
      check("startup_req", 64'(bus0.mem_req), 64'(1));
      check("startup_addr", 64'(bus0.mem_addr), 64'(0));

      // sequential stream
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      wait_drain(100, "stream_drain");
      bus0.instr_ready = 1'b0;

      // fill with backpressure, then a single pop frees exactly one slot
      reset0();
      repeat (40) tick();
      check("fill_acks", 64'(ack_cnt), 64'(4));
      check("fill_req", 64'(bus0.mem_req), 64'(0));
      check("fill_count", 64'(dbg_count0), 64'(4));
      check("fill_head", 64'(bus0.instr_addr), 64'(0));
      exp_q.push_back(32'h0);
      bus0.instr_ready = 1'b1;
      tick();
      bus0.instr_ready = 1'b0;
      check("refill_req", 64'(bus0.mem_req), 64'(1));
      check("refill_addr", 64'(bus0.mem_addr), 64'(32'h10));
      repeat (20) tick();
      check("refill_acks", 64'(ack_cnt), 64'(5));
      check("refill_idle", 64'(bus0.mem_req), 64'(0));
      check("refill_count", 64'(dbg_count0), 64'(4));
      check("refill_drain", 64'(exp_q.size()), 64'(0));

      // redirect while the fetch at 0x8 is outstanding
      reset0();
      bus0.instr_ready = 1'b1;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      wait_req_at(0, 32'h8, 40, "mid_req_at8");
      check("mid_pre_drain", 64'(exp_q.size()), 64'(0));
      bus0.redirect = 1'b1; bus0.redirect_pc = 32'h200;
      exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      tick();
      bus0.redirect = 1'b0;
      check("mid_valid", 64'(bus0.instr_valid), 64'(0));
      check("mid_state", 64'(dbg_state0), 64'(2));
      check("mid_stale_addr", 64'(bus0.mem_addr), 64'(32'h8));
      for (int n = 0; n < 10 && bus0.mem_req; n++) tick();
      check("mid_stale_done", 64'(bus0.mem_req), 64'(0));
      tick();
      check("mid_new_req", 64'(bus0.mem_req), 64'(1));
      check("mid_new_addr", 64'(bus0.mem_addr), 64'(32'h200));
      wait_drain(60, "mid_drain");
      bus0.instr_ready = 1'b0;

      // ack and redirect in the same cycle
      rst0_n = 1'b0;
      tick();
      auto_mem = 1'b0;
      bus0.mem_ack = 1'b0;
      exp_q.delete();
      rst0_n = 1'b1;
      bus0.instr_ready = 1'b1;
      exp_q.push_back(32'h0);
      wait_req_at(0, 32'h0, 5, "sim_req0");
      ack_pulse(0, 32'h0 ^ MAGIC);
      wait_req_at(0, 32'h4, 5, "sim_req4");
      bus0.mem_ack = 1'b1; bus0.mem_rdata = 32'h4 ^ MAGIC;
      bus0.redirect = 1'b1; bus0.redirect_pc = 32'h80;
      tick();
      bus0.mem_ack = 1'b0; bus0.redirect = 1'b0;
      check("sim_valid", 64'(bus0.instr_valid), 64'(0));
      check("sim_req_drop", 64'(bus0.mem_req), 64'(0));
      tick();
      check("sim_new_req", 64'(bus0.mem_req), 64'(1));
      check("sim_new_addr", 64'(bus0.mem_addr), 64'(32'h80));
      exp_q.push_back(32'h80);
      ack_pulse(0, 32'h80 ^ MAGIC);
      wait_drain(10, "sim_drain");
      bus0.instr_ready = 1'b0;

      // mem_hold blocks issue from IDLE but not an issued request
      rst0_n = 1'b0;
      bus0.mem_hold = 1'b1;
      auto_mem = 1'b1;
      tick();
      exp_q.delete();
      rst0_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         check("hold_idle_req", 64'(bus0.mem_req), 64'(0));
      end
      bus0.mem_hold = 1'b0;
      tick();
      check("hold_release_req", 64'(bus0.mem_req), 64'(1));
      check("hold_release_addr", 64'(bus0.mem_addr), 64'(0));
      bus0.mem_hold = 1'b1;
      for (int n = 0; n < 10 && dbg_count0 != 3'd1; n++) tick();
      check("hold_req_done", 64'(dbg_count0), 64'(1));
      for (int n = 0; n < 3; n++) begin
         tick();
         check("hold_after_req", 64'(bus0.mem_req), 64'(0));
      end
      bus0.mem_hold = 1'b0;
      tick();
      check("hold_next_addr", 64'(bus0.mem_addr), 64'(32'h4));
      check("hold_next_req", 64'(bus0.mem_req), 64'(1));

      // address wrap and asynchronous reset mid-request on dut1
      rst1_n = 1'b1;
      wait_req_at(1, 32'hFFFF_FFF8, 3, "wrap_req_f8");
      ack_pulse(1, 32'hFFFF_FFF8 ^ MAGIC);
      wait_req_at(1, 32'hFFFF_FFFC, 3, "wrap_req_fc");
      ack_pulse(1, 32'hFFFF_FFFC ^ MAGIC);
      wait_req_at(1, 32'h0, 3, "wrap_req_0");
      check("wrap_valid", 64'(bus1.instr_valid), 64'(1));
      check("wrap_head_addr", 64'(bus1.instr_addr), 64'(32'hFFFF_FFF8));
      check("wrap_head_data", 64'(bus1.instr_data), 64'(32'hFFFF_FFF8 ^ MAGIC));
      check("wrap_count", 64'(dbg_count1), 64'(2));
      #2;
      rst1_n = 1'b0;
      #1;
      check("async_rst_req", 64'(bus1.mem_req), 64'(0));
      check("async_rst_valid", 64'(bus1.instr_valid), 64'(0));
      check("async_rst_count", 64'(dbg_count1), 64'(0));

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
